// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg: shared state encoding and register/stride constants
package ldm_stm_sequencer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;
  localparam int SP_IDX = 13;
  localparam int LR_IDX = 14;
  localparam int PC_IDX = 15;
  localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/ldm_stm_sequencer_lowest_bit_enc.sv
// lowest_bit_enc: combinational index of the lowest set bit of a mask
module lowest_bit_enc #(
  parameter int LIST_W = 9,
  parameter int IDX_W = $clog2(LIST_W)
) (
  input  logic [LIST_W-1:0] mask,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);
  always_comb begin
    idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--)
      if (mask[i]) idx = IDX_W'(i);
  end
  assign valid = |mask;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle PUSH/POP/LDMIA/STMIA register/memory sequencer
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 9,
  parameter int XTRA_ST_REG = LR_IDX,
  parameter int XTRA_LD_REG = PC_IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_load,
  input  logic              decrement,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  output logic              busy,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [3:0]        rf_rd_reg,
  output logic [3:0]        rf_wr_reg,
  output logic              rf_we,
  output logic              rf_wsel_base,
  output logic [ADDR_W-1:0] base_wb_val,
  output logic              pc_load,
  output logic              done
);
  localparam int IDX_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);
  state_t state_q, state_d;
  logic [LIST_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] cur_q, cur_d, base_wb_q, base_wb_d, span;
  logic [3:0] base_reg_q, base_reg_d, reg_num;
  logic op_load_q, op_load_d, wb_en_q, wb_en_d;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic valid, in_list, xfer, wb, ld, ld_pc, wr_base;
  lowest_bit_enc #(.LIST_W(LIST_W), .IDX_W(IDX_W)) u_enc (
    .mask (mask_q),
    .idx  (idx),
    .valid(valid)
  );
  always_comb begin
    cnt = '0;
    for (int i = 0; i < LIST_W; i++) cnt = cnt + CNT_W'(reg_list[i]);
  end
  assign span = ADDR_W'(cnt) << 2;
  assign in_list = !base_reg[3] ? reg_list[base_reg[2:0]]
                 : reg_list[LIST_W-1] && base_reg == 4'(op_load ? XTRA_LD_REG : XTRA_ST_REG);
  assign xfer = state_q == S_XFER;
  assign wb = state_q == S_WB;
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    cur_d = cur_q;
    base_wb_d = base_wb_q;
    base_reg_d = base_reg_q;
    op_load_d = op_load_q;
    wb_en_d = wb_en_q;
    if (state_q == S_IDLE && start) begin
      mask_d = reg_list;
      op_load_d = op_load;
      base_reg_d = base_reg;
      cur_d = decrement ? base_val - span : base_val;
      base_wb_d = decrement ? base_val - span : base_val + span;
      wb_en_d = |reg_list && !(op_load && in_list);
      state_d = |reg_list ? S_XFER : S_WB;
    end else if (xfer) begin
      mask_d = mask_q & ~(LIST_W'(1) << idx);
      cur_d = cur_q + ADDR_W'(WORD_STRIDE);
      state_d = (mask_d == '0 || !valid) ? S_WB : S_XFER;
    end else if (wb) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q <= '0;
      cur_q <= '0;
      base_wb_q <= '0;
      base_reg_q <= '0;
      op_load_q <= 1'b0;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      cur_q <= cur_d;
      base_wb_q <= base_wb_d;
      base_reg_q <= base_reg_d;
      op_load_q <= op_load_d;
      wb_en_q <= wb_en_d;
    end
  end
  assign reg_num = idx == IDX_W'(LIST_W - 1) ? 4'(op_load_q ? XTRA_LD_REG : XTRA_ST_REG) : 4'(idx);
  assign ld = xfer && op_load_q;
  assign ld_pc = ld && reg_num == 4'(PC_IDX);
  assign wr_base = wb && wb_en_q;
  assign busy = state_q != S_IDLE;
  assign stall = (start && state_q == S_IDLE) || xfer;
  assign mem_addr = xfer ? cur_q : '0;
  assign mem_we = xfer && !op_load_q;
  assign mem_be = xfer ? 4'hF : 4'h0;
  assign rf_rd_reg = mem_we ? reg_num : 4'd0;
  assign rf_wr_reg = (ld && !ld_pc) ? reg_num : wr_base ? base_reg_q : 4'd0;
  assign rf_we = (ld && !ld_pc) || wr_base;
  assign rf_wsel_base = wr_base;
  assign base_wb_val = wb ? base_wb_q : '0;
  assign pc_load = ld_pc;
  assign done = wb;
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed table-driven check of the load/store-multiple sequencer
module tb_ldm_stm_sequencer;
  typedef struct packed {
    logic busy, stall;
    logic [31:0] addr;
    logic we;
    logic [3:0] be, rd, wr;
    logic rwe, wsel;
    logic [31:0] bwb;
    logic pcl, done;
  } out_t;
  typedef struct {
    string name;
    logic r, s, op, dec;
    logic [8:0] list;
    logic [3:0] breg;
    logic [31:0] bval;
    out_t exp;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, op_load = 0, decrement = 0;
  logic [8:0] reg_list = 0;
  logic [3:0] base_reg = 0;
  logic [31:0] base_val = 0;
  logic busy, stall, mem_we, rf_we, rf_wsel_base, pc_load, done;
  logic [31:0] mem_addr, base_wb_val;
  logic [3:0] mem_be, rf_rd_reg, rf_wr_reg;
  int checks = 0, errors = 0;
  vec_t vecs[$];
  out_t got;
  ldm_stm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_load(op_load), .decrement(decrement),
    .reg_list(reg_list), .base_reg(base_reg), .base_val(base_val), .busy(busy), .stall(stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .rf_rd_reg(rf_rd_reg),
    .rf_wr_reg(rf_wr_reg), .rf_we(rf_we), .rf_wsel_base(rf_wsel_base),
    .base_wb_val(base_wb_val), .pc_load(pc_load), .done(done)
  );
  always #5 clk = ~clk;
  function automatic out_t o(logic b, logic st, logic [31:0] a, logic w, logic [3:0] be,
                             logic [3:0] rd, logic [3:0] wr, logic rwe, logic ws,
                             logic [31:0] bwb, logic pcl, logic dn);
    return {b, st, a, w, be, rd, wr, rwe, ws, bwb, pcl, dn};
  endfunction
  function automatic out_t z();
    return o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic out_t st();
    return o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic out_t xs(logic [31:0] a, logic [3:0] rd);
    return o(1, 1, a, 1, 4'hF, rd, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic out_t xl(logic [31:0] a, logic [3:0] wr, logic rwe, logic pcl);
    return o(1, 1, a, 0, 4'hF, 0, wr, rwe, 0, 0, pcl, 0);
  endfunction
  function automatic out_t wbo(logic [3:0] wr, logic rwe, logic [31:0] bwb);
    return o(1, 0, 0, 0, 0, 0, wr, rwe, rwe, bwb, 0, 1);
  endfunction
  task automatic add(string n, logic r, logic s, logic op, logic dc, logic [8:0] l,
                     logic [3:0] br, logic [31:0] bv, out_t e);
    vec_t v;
    v.name = n; v.r = r; v.s = s; v.op = op; v.dec = dc;
    v.list = l; v.breg = br; v.bval = bv; v.exp = e;
    vecs.push_back(v);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1);
  end
  initial begin
    int n, nwe;
    logic [31:0] last_addr;
    add("reset_idle", 1, 0, 0, 0, 0, 0, 0, z());
    add("push_start", 0, 1, 0, 1, 9'h105, 13, 32'h100, st());
    add("push_r0", 0, 0, 0, 0, 0, 0, 0, xs(32'hF4, 0));
    add("push_r2", 0, 0, 0, 0, 0, 0, 0, xs(32'hF8, 2));
    add("push_lr", 0, 0, 0, 0, 0, 0, 0, xs(32'hFC, 14));
    add("push_wb", 0, 0, 0, 0, 0, 0, 0, wbo(13, 1, 32'hF4));
    add("push_idle", 0, 0, 0, 0, 0, 0, 0, z());
    add("pop_start", 0, 1, 1, 0, 9'h102, 13, 32'hF8, st());
    add("pop_r1", 0, 0, 0, 0, 0, 0, 0, xl(32'hF8, 1, 1, 0));
    add("pop_pc", 0, 0, 0, 0, 0, 0, 0, xl(32'hFC, 0, 0, 1));
    add("pop_wb", 0, 0, 0, 0, 0, 0, 0, wbo(13, 1, 32'h100));
    add("pop_idle", 0, 0, 0, 0, 0, 0, 0, z());
    add("ldm_start", 0, 1, 1, 0, 9'h018, 3, 32'h40, st());
    add("ldm_r3", 0, 0, 0, 0, 0, 0, 0, xl(32'h40, 3, 1, 0));
    add("ldm_r4", 0, 0, 0, 0, 0, 0, 0, xl(32'h44, 4, 1, 0));
    add("ldm_wb_suppressed", 0, 0, 0, 0, 0, 0, 0, wbo(0, 0, 32'h48));
    add("ldm_idle", 0, 0, 0, 0, 0, 0, 0, z());
    add("empty_start", 0, 1, 0, 0, 9'h000, 13, 32'h80, st());
    add("empty_wb", 0, 0, 0, 0, 0, 0, 0, wbo(0, 0, 32'h80));
    add("empty_idle", 0, 0, 0, 0, 0, 0, 0, z());
    add("wrapd_start", 0, 1, 0, 1, 9'h001, 13, 32'h0, st());
    add("wrapd_r0", 0, 0, 0, 0, 0, 0, 0, xs(32'hFFFF_FFFC, 0));
    add("wrapd_wb", 0, 0, 0, 0, 0, 0, 0, wbo(13, 1, 32'hFFFF_FFFC));
    add("wrapi_start", 0, 1, 0, 0, 9'h0C0, 5, 32'hFFFF_FFFC, st());
    add("wrapi_r6", 0, 0, 0, 0, 0, 0, 0, xs(32'hFFFF_FFFC, 6));
    add("wrapi_r7", 0, 0, 0, 0, 0, 0, 0, xs(32'h0, 7));
    add("wrapi_wb", 0, 0, 0, 0, 0, 0, 0, wbo(5, 1, 32'h4));
    add("stbase_start", 0, 1, 0, 0, 9'h006, 1, 32'h10, st());
    add("stbase_r1", 0, 0, 0, 0, 0, 0, 0, xs(32'h10, 1));
    add("stbase_r2", 0, 0, 0, 0, 0, 0, 0, xs(32'h14, 2));
    add("stbase_wb", 0, 0, 0, 0, 0, 0, 0, wbo(1, 1, 32'h18));
    add("hold_start", 0, 1, 0, 1, 9'h002, 13, 32'h200, st());
    add("hold_xfer", 0, 1, 0, 1, 9'h002, 13, 32'h200, xs(32'h1FC, 1));
    add("hold_wb", 0, 1, 0, 1, 9'h002, 13, 32'h200, wbo(13, 1, 32'h1FC));
    add("hold_restart", 0, 1, 0, 1, 9'h002, 13, 32'h200, st());
    add("hold_xfer2", 0, 0, 0, 0, 0, 0, 0, xs(32'h1FC, 1));
    add("hold_wb2", 0, 0, 0, 0, 0, 0, 0, wbo(13, 1, 32'h1FC));
    add("hold_idle", 0, 0, 0, 0, 0, 0, 0, z());
    add("rst_start", 0, 1, 0, 1, 9'h0FF, 13, 32'h100, st());
    add("rst_x1", 0, 0, 0, 0, 0, 0, 0, xs(32'hE0, 0));
    add("rst_x2", 1, 0, 0, 0, 0, 0, 0, xs(32'hE4, 1));
    add("rst_after", 0, 0, 0, 0, 0, 0, 0, z());
    add("rst_idle", 0, 0, 0, 0, 0, 0, 0, z());
    repeat (2) @(negedge clk);
    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].r; start = vecs[k].s; op_load = vecs[k].op; decrement = vecs[k].dec;
      reg_list = vecs[k].list; base_reg = vecs[k].breg; base_val = vecs[k].bval;
      #1;
      got = {busy, stall, mem_addr, mem_we, mem_be, rf_rd_reg, rf_wr_reg, rf_we,
             rf_wsel_base, base_wb_val, pc_load, done};
      checks++;
      if (got !== vecs[k].exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", vecs[k].name, got, vecs[k].exp);
      end
    end
    @(negedge clk);
    rst = 0; start = 1; op_load = 0; decrement = 0;
    reg_list = 9'h1FF; base_reg = 2; base_val = 32'h1000;
    n = 1; nwe = 0; last_addr = 0;
    #1;
    while (!done && n < 30) begin
      @(negedge clk);
      start = 0;
      n++;
      #1;
      if (mem_we) begin
        nwe++;
        last_addr = mem_addr;
      end
    end
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL stm9_latency: got done in cycle %0d, required cycle 11", n);
    end
    checks++;
    if (nwe != 9 || last_addr != 32'h1020) begin
      errors++;
      $display("FAIL stm9_writes: got %0d writes last %h, required 9 writes last 00001020", nwe, last_addr);
    end
    checks++;
    if (base_wb_val !== 32'h1024 || rf_wr_reg !== 4'd2 || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL stm9_wb: got base %h reg %0d we %b, required 00001024 2 1", base_wb_val, rf_wr_reg, rf_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stm9_single_done: got done %b busy %b, required 0 0", done, busy);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
